// File: rtl/reg_file_arbiter.sv
// Two-requester front end for a 16x8 register file: arbitrates A/B, sequences one access at a time.
// Define RF_ARB_FIXED_PRIO_EN to give A absolute priority instead of round-robin.
module reg_file_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_rs,
    input  logic [ADDR_W-1:0] a_rt,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_rs,
    input  logic [ADDR_W-1:0] b_rt,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              a_rsp_valid,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] rsp_rs_data,
    output logic [DATA_W-1:0] rsp_rt_data,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_rs,
    output logic [ADDR_W-1:0] rf_rt,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(NUM_REGS);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rspRs;
    logic [DATA_W-1:0] r_rspRt;
    logic              w_grantA;
    logic              w_grantB;
    logic              w_accept;

    function automatic logic isLegal(input logic [ADDR_W-1:0] addr);
        return (addr != '0) && (addr <= MaxAddr);
    endfunction

`ifdef RF_ARB_FIXED_PRIO_EN
    assign w_grantA = a_valid;
`else
    logic r_lastGrantB;

    assign w_grantA = a_valid & (~b_valid | r_lastGrantB);

    // Last-grant only moves on an actual accept; reset favours A on first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGrantB <= 1'b1;
        end else if (w_accept) begin
            r_lastGrantB <= w_grantB;
        end
    end
`endif

    assign w_grantB = b_valid & ~w_grantA;
    assign w_accept = (r_state == ST_IDLE) & (a_valid | b_valid);

    assign rf_rs       = r_rs;
    assign rf_rt       = r_rt;
    assign rsp_rs_data = r_rspRs;
    assign rsp_rt_data = r_rspRt;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Strobes are masked by rst so a reset landing mid-transaction never writes or acks.
    always_comb begin
        w_nextState = r_state;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        rf_rw       = 1'b0;
        rf_rd       = '0;
        rf_wdata    = '0;
        case (r_state)
            ST_IDLE: begin
                a_ready = w_grantA & ~rst;
                b_ready = w_grantB & ~rst;
                if (a_valid | b_valid) begin
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_we) begin
                    if (isLegal(r_rd) && !rst) begin
                        rf_rw    = 1'b1;
                        rf_rd    = r_rd;
                        rf_wdata = r_wdata;
                    end
                    w_nextState = ST_RESP;
                end else begin
                    w_nextState = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_nextState = ST_RESP;
            end
            ST_RESP: begin
                a_rsp_valid = ~r_owner & ~rst;
                b_rsp_valid = r_owner & ~rst;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_wdata <= '0;
            r_rspRs <= '0;
            r_rspRt <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grantB;
                r_we    <= w_grantA ? a_we    : b_we;
                r_rs    <= w_grantA ? a_rs    : b_rs;
                r_rt    <= w_grantA ? a_rt    : b_rt;
                r_rd    <= w_grantA ? a_rd    : b_rd;
                r_wdata <= w_grantA ? a_wdata : b_wdata;
            end
            // Out-of-range read addresses return zero whatever the file drives.
            if (r_state == ST_CAPTURE) begin
                r_rspRs <= isLegal(r_rs) ? rf_rs_data : '0;
                r_rspRt <= isLegal(r_rt) ? rf_rt_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scoreboard bench for reg_file_arbiter with a behavioural 16x8 register file model.
// Expected responses and reg-file write strobes are queued at stimulus time and checked by monitors.
module tb_reg_file_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_we, a_ready;
    logic [4:0] a_rs, a_rt, a_rd;
    logic [7:0] a_wdata;
    logic       b_valid, b_we, b_ready;
    logic [4:0] b_rs, b_rt, b_rd;
    logic [7:0] b_wdata;
    logic       a_rsp_valid, b_rsp_valid;
    logic [7:0] rsp_rs_data, rsp_rt_data;
    logic       rf_rw;
    logic [4:0] rf_rs, rf_rt, rf_rd;
    logic [7:0] rf_wdata;
    logic [7:0] rfRsData, rfRtData;
    logic       busy;

    typedef struct {
        bit       ownerB;
        bit       we;
        bit [7:0] rsData;
        bit [7:0] rtData;
        int       cyc;
    } rsp_t;

    typedef struct {
        int       cyc;
        bit [4:0] rd;
        bit [7:0] data;
    } wr_t;

    rsp_t     expQ[$];
    wr_t      wrQ[$];
    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    bit [7:0] expRs = 8'h00;
    bit [7:0] expRt = 8'h00;
    logic [7:0] mem [1:16];
    bit       memInit = 1'b0;

    reg_file_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_we(a_we), .a_rs(a_rs), .a_rt(a_rt), .a_rd(a_rd),
        .a_wdata(a_wdata), .a_ready(a_ready),
        .b_valid(b_valid), .b_we(b_we), .b_rs(b_rs), .b_rt(b_rt), .b_rd(b_rd),
        .b_wdata(b_wdata), .b_ready(b_ready),
        .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid),
        .rsp_rs_data(rsp_rs_data), .rsp_rt_data(rsp_rt_data),
        .rf_rw(rf_rw), .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rf_rs_data(rfRsData), .rf_rt_data(rfRtData),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model; out-of-range reads return 0xEE so the DUT's zeroing is visible.
    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 1; i <= 16; i++) mem[i] <= 8'(16 + i);
            memInit <= 1'b1;
        end else if (rf_rw) begin
            if (rf_rd >= 5'd1 && rf_rd <= 5'd16) mem[rf_rd] <= rf_wdata;
        end
        rfRsData <= (rf_rs >= 5'd1 && rf_rs <= 5'd16) ? mem[rf_rs] : 8'hEE;
        rfRtData <= (rf_rt >= 5'd1 && rf_rt <= 5'd16) ? mem[rf_rt] : 8'hEE;
    end

    // Response and reg-file strobe monitor.
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (a_rsp_valid || b_rsp_valid) begin
            total++;
            if (a_rsp_valid && b_rsp_valid) begin
                bad++;
                $display("[TB] FAIL rsp_both: a_rsp_valid and b_rsp_valid together at cycle %0d", cyc);
            end else if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL rsp_unexpected: got ownerB=%0b at cycle %0d, none expected", b_rsp_valid, cyc);
            end else begin
                e = expQ.pop_front();
                if (b_rsp_valid != e.ownerB || cyc != e.cyc || rsp_rs_data != e.rsData || rsp_rt_data != e.rtData)
                    begin
                    bad++;
                    $display("[TB] FAIL rsp_check: got ownerB=%0b cyc=%0d rs=%h rt=%h, want ownerB=%0b cyc=%0d rs=%h rt=%h",
                             b_rsp_valid, cyc, rsp_rs_data, rsp_rt_data, e.ownerB, e.cyc, e.rsData, e.rtData);
                end
            end
        end
        total++;
        if (rf_rw) begin
            if (wrQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL rf_write_unexpected: rf_rw=1 rd=%0d data=%h at cycle %0d", rf_rd, rf_wdata, cyc);
            end else begin
                w = wrQ.pop_front();
                if (cyc != w.cyc || rf_rd != w.rd || rf_wdata != w.data) begin
                    bad++;
                    $display("[TB] FAIL rf_write: got cyc=%0d rd=%0d data=%h, want cyc=%0d rd=%0d data=%h",
                             cyc, rf_rd, rf_wdata, w.cyc, w.rd, w.data);
                end
            end
        end else if (rf_rd != 5'd0 || rf_wdata != 8'h00) begin
            bad++;
            $display("[TB] FAIL rf_idle_bus: rd=%0d data=%h with rf_rw=0, want 0/00 at cycle %0d", rf_rd, rf_wdata, cyc);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic void pushExp(input bit ownerB, input bit we, input bit [7:0] rsd, input bit [7:0] rtd,
                                    input int c);
        rsp_t e;
        if (!we) begin
            expRs = rsd;
            expRt = rtd;
        end
        e.ownerB = ownerB;
        e.we     = we;
        e.rsData = expRs;
        e.rtData = expRt;
        e.cyc    = c;
        expQ.push_back(e);
    endfunction

    function automatic void pushWr(input int c, input bit [4:0] rd, input bit [7:0] data);
        wr_t w;
        w.cyc  = c;
        w.rd   = rd;
        w.data = data;
        wrQ.push_back(w);
    endfunction

    // Drives one request and holds it until accepted, then drops valid after the accept edge.
    task automatic applyStimulus(input bit isB, input bit we, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [7:0] wd);
        bit acc = 1'b0;
        if (!isB) begin
            a_valid = 1'b1; a_we = we; a_rs = rs; a_rt = rt; a_rd = rd; a_wdata = wd;
        end else begin
            b_valid = 1'b1; b_we = we; b_rs = rs; b_rt = rt; b_rd = rd; b_wdata = wd;
        end
        #1;
        for (int i = 0; i < 60; i++) begin
            if (isB ? b_ready : a_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: requester %s got ready=0, want 1", isB ? "B" : "A");
        end else begin
            @(posedge clk);
            #1;
        end
        if (!isB) a_valid = 1'b0;
        else      b_valid = 1'b0;
    endtask

    // Waits until all expected traffic has been seen, then aligns to the next (idle) cycle.
    task automatic waitDrain();
        for (int i = 0; i < 60 && (expQ.size() != 0 || wrQ.size() != 0); i++) begin
            @(negedge clk);
            #2;
        end
        checkOutput("drain_pending", 32'(expQ.size() + wrQ.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic single(input bit isB, input bit we, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [7:0] wd, input bit [7:0] rsd, input bit [7:0] rtd);
        int s;
        waitDrain();
        s = cyc;
        if (we && rd >= 5'd1 && rd <= 5'd16) pushWr(s + 1, rd, wd);
        pushExp(isB, we, rsd, rtd, we ? s + 2 : s + 3);
        applyStimulus(isB, we, rs, rt, rd, wd);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s;
        rst = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_rs = '0; a_rt = '0; a_rd = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_rs = '0; b_rt = '0; b_rd = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rf_rw", 32'(rf_rw), 32'd0);
        checkOutput("reset_rsp_rs", 32'(rsp_rs_data), 32'd0);
        checkOutput("reset_rsp_rt", 32'(rsp_rt_data), 32'd0);
        checkOutput("reset_rf_rs", 32'(rf_rs), 32'd0);

        // Legal write then read-back, and a B-only read so B holds last grant.
        single(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 8'h5A, 8'h00, 8'h00);
        single(1'b0, 1'b0, 5'd3, 5'd4, 5'd0, 8'h00, 8'h5A, 8'h14);
        single(1'b1, 1'b0, 5'd7, 5'd8, 5'd0, 8'h00, 8'h17, 8'h18);

        // Contention with last grant B: A first, B four cycles later.
        waitDrain();
        s = cyc;
        pushExp(1'b0, 1'b0, 8'h11, 8'h12, s + 3);
        pushExp(1'b1, 1'b0, 8'h12, 8'h11, s + 7);
        fork
            applyStimulus(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 8'h00);
            applyStimulus(1'b1, 1'b0, 5'd2, 5'd1, 5'd0, 8'h00);
        join

        // Out-of-range writes are dropped but acked; out-of-range reads return zero.
        single(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 8'h77, 8'h00, 8'h00);
        single(1'b0, 1'b1, 5'd0, 5'd0, 5'd17, 8'h88, 8'h00, 8'h00);
        single(1'b0, 1'b0, 5'd0, 5'd17, 5'd0, 8'h00, 8'h00, 8'h00);

        // Reset landing in ISSUE of a write must suppress the strobe and the ack.
        single(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 8'h33, 8'h00, 8'h00);
        waitDrain();
        a_valid = 1'b1; a_we = 1'b1; a_rs = '0; a_rt = '0; a_rd = 5'd5; a_wdata = 8'hFF;
        #1;
        checkOutput("rst_case_accept", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_case_rf_rw", 32'(rf_rw), 32'd0);
        checkOutput("rst_case_ack", 32'(a_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expRs = 8'h00;
        expRt = 8'h00;
        checkOutput("rst_case_busy", 32'(busy), 32'd0);
        checkOutput("rst_case_rsp_rs", 32'(rsp_rs_data), 32'd0);
        single(1'b0, 1'b0, 5'd5, 5'd3, 5'd0, 8'h00, 8'h33, 8'h5A);

        // Last grant is now A: three back-to-back A reads against one B read.
        waitDrain();
        s = cyc;
`ifdef RF_ARB_FIXED_PRIO_EN
        pushExp(1'b0, 1'b0, 8'h11, 8'h19, s + 3);
        pushExp(1'b0, 1'b0, 8'h12, 8'h1A, s + 7);
        pushExp(1'b0, 1'b0, 8'h5A, 8'h1B, s + 11);
        pushExp(1'b1, 1'b0, 8'h20, 8'h1F, s + 15);
`else
        pushExp(1'b1, 1'b0, 8'h20, 8'h1F, s + 3);
        pushExp(1'b0, 1'b0, 8'h11, 8'h19, s + 7);
        pushExp(1'b0, 1'b0, 8'h12, 8'h1A, s + 11);
        pushExp(1'b0, 1'b0, 8'h5A, 8'h1B, s + 15);
`endif
        fork
            begin
                applyStimulus(1'b0, 1'b0, 5'd1, 5'd9, 5'd0, 8'h00);
                applyStimulus(1'b0, 1'b0, 5'd2, 5'd10, 5'd0, 8'h00);
                applyStimulus(1'b0, 1'b0, 5'd3, 5'd11, 5'd0, 8'h00);
            end
            applyStimulus(1'b1, 1'b0, 5'd16, 5'd15, 5'd0, 8'h00);
        join

        waitDrain();
        repeat (4) @(negedge clk);
        checkOutput("final_busy", 32'(busy), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
